adder_stream_adapter: RTL and testbench

Ready/valid streaming front-end for `pipelined_adder_core`, the fixed-latency carry-select adder. The core accepts one operand set per cycle and has no stall input. This block sits between an upstream producer and a downstream consumer that can both stall. It issues operands into the core only when result storage is guaranteed, and it collects the core's results into a FIFO. Within the ALU datapath, it is the consumer of the core's `v_out`/`sum` interface.

---
 rtl/adder_stream_adapter.sv | 161 ++++++++++++++++
 tb/tb_adder_stream_adapter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_stream_adapter.sv
// Ready/valid wrapper around a 3-stage carry-select adder core. Operands issue
// only against a free result slot, so the stall-less core can never overrun the FIFO.

module pipelined_adder_core #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLOCK = 8
) (
    input  logic             clk_i,
    input  logic             v_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             v_o,
    output logic [WIDTH-1:0] sum_o
);

    localparam int unsigned NB = WIDTH / BLOCK;

    logic [NB-1:0][BLOCK-1:0] s0_d, s1_d, s0_q, s1_q;
    logic [NB-1:0]            c0_d, c1_d, c0_q, c1_q;
    logic                     cin_q;
    logic                     v1_q, v2_q, v3_q;
    logic [WIDTH-1:0]         sel_d, sel_q, sum_q;

    // Stage 1: each block computes its sum for both possible carry-ins.
    always_comb begin
        s0_d = '0;
        s1_d = '0;
        c0_d = '0;
        c1_d = '0;
        for (int k = 0; k < int'(NB); k++) begin
            {c0_d[k], s0_d[k]} = {1'b0, a_i[k*BLOCK +: BLOCK]} + {1'b0, b_i[k*BLOCK +: BLOCK]};
            {c1_d[k], s1_d[k]} = {1'b0, a_i[k*BLOCK +: BLOCK]} + {1'b0, b_i[k*BLOCK +: BLOCK]}
                                 + (BLOCK+1)'(1);
        end
    end

    // Stage 2: ripple the block carries through the select muxes.
    always_comb begin
        logic cy;
        cy    = cin_q;
        sel_d = '0;
        for (int k = 0; k < int'(NB); k++) begin
            sel_d[k*BLOCK +: BLOCK] = cy ? s1_q[k] : s0_q[k];
            cy                      = cy ? c1_q[k] : c0_q[k];
        end
    end

    // Datapath and valid pipeline carry no reset; the adapter tracks validity itself.
    always_ff @(posedge clk_i) begin
        v1_q  <= v_i;
        s0_q  <= s0_d;
        s1_q  <= s1_d;
        c0_q  <= c0_d;
        c1_q  <= c1_d;
        cin_q <= cin_i;
        v2_q  <= v1_q;
        sel_q <= sel_d;
        v3_q  <= v2_q;
        sum_q <= sel_q;
    end

    assign v_o   = v3_q;
    assign sum_o = sum_q;

endmodule

module adder_stream_adapter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLOCK = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [WIDTH-1:0] s_a_i,
    input  logic [WIDTH-1:0] s_b_i,
    input  logic             s_cin_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_sum_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = AW + 1;
    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

    logic [OW-1:0]    occ_q, occ_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [2:0]       sv_q, sv_d;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             issue_c, pop_c, push_c;
    logic [OW-1:0]    inflight_c, count_c;
    logic             core_v;
    logic [WIDTH-1:0] core_sum;

    pipelined_adder_core #(
        .WIDTH (WIDTH),
        .BLOCK (BLOCK)
    ) u_core (
        .clk_i (clk_i),
        .v_i   (issue_c),
        .a_i   (s_a_i),
        .b_i   (s_b_i),
        .cin_i (s_cin_i),
        .v_o   (core_v),
        .sum_o (core_sum)
    );

    // occ reserves a FIFO slot per issue, so a free credit means a free slot at write time.
    assign s_ready_o  = !rst_i && (occ_q < DEPTH_C);
    assign issue_c    = s_valid_i && s_ready_o;
    assign inflight_c = OW'(sv_q[0]) + OW'(sv_q[1]) + OW'(sv_q[2]);
    assign count_c    = occ_q - inflight_c;
    assign m_valid_o  = (count_c != '0);
    assign pop_c      = m_valid_o && m_ready_i;
    assign push_c     = sv_q[2];
    assign m_sum_o    = m_valid_o ? mem[rd_ptr_q] : '0;

    always_comb begin
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        sv_d     = {sv_q[1:0], issue_c};
        if (issue_c && !pop_c) begin
            occ_d = occ_q + OW'(1);
        end else if (!issue_c && pop_c) begin
            occ_d = occ_q - OW'(1);
        end
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sv_q     <= '0;
        end else begin
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sv_q     <= sv_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_c) begin
            mem[wr_ptr_q] <= core_sum;
        end
    end

endmodule

// File: tb/tb_adder_stream_adapter.sv
// Directed and randomised checks for adder_stream_adapter against an
// in-order timing model of issue, 4-cycle result latency and credit limit.

module tb_adder_stream_adapter;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         s_valid_i = 1'b0;
    logic         s_ready_o;
    logic [W-1:0] s_a_i = '0;
    logic [W-1:0] s_b_i = '0;
    logic         s_cin_i = 1'b0;
    logic         m_valid_o;
    logic         m_ready_i = 1'b0;
    logic [W-1:0] m_sum_o;

    always #5 clk = ~clk;

    adder_stream_adapter #(
        .WIDTH (32),
        .BLOCK (8),
        .DEPTH (8)
    ) u_dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .s_a_i     (s_a_i),
        .s_b_i     (s_b_i),
        .s_cin_i   (s_cin_i),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_sum_o   (m_sum_o)
    );

    typedef struct {
        logic [W-1:0] sum;
        int           avail;
    } exp_t;

    exp_t         pend[$];
    logic [W-1:0] popped[$];
    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           n_pop = 0;
    int           n_iss = 0;
    int           since_rst = 0;
    logic         obs_ready, obs_valid;
    logic [W-1:0] obs_sum;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, sample 1ns later, then advance the model.
    task automatic step(input logic r, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic mr);
        logic         exp_ready, exp_valid;
        logic [W-1:0] exp_sum;
        exp_t         e;
        @(negedge clk);
        rst_i     = r;
        s_valid_i = v;
        s_a_i     = a;
        s_b_i     = b;
        s_cin_i   = cin;
        m_ready_i = mr;
        #1;
        obs_ready = s_ready_o;
        obs_valid = m_valid_o;
        obs_sum   = m_sum_o;
        exp_ready = !r && (pend.size() < 8);
        exp_valid = (pend.size() != 0) && (pend[0].avail <= cyc);
        exp_sum   = exp_valid ? pend[0].sum : '0;
        check("s_ready", W'(obs_ready), W'(exp_ready));
        check("m_valid", W'(obs_valid), W'(exp_valid));
        check("m_sum", obs_sum, exp_sum);
        if (obs_valid && mr) begin
            n_pop++;
            popped.push_back(obs_sum);
        end
        if (r) begin
            pend.delete();
        end else begin
            if (exp_valid && mr) void'(pend.pop_front());
            if (v && exp_ready) begin
                e.sum   = a + b + W'(cin);
                e.avail = cyc + 4;
                pend.push_back(e);
                n_iss++;
            end
        end
        cyc++;
    endtask

    task automatic idle(input logic mr);
        step(1'b0, 1'b0, '0, '0, 1'b0, mr);
    endtask

    // The core's unreset valid pipeline must track the shadow valids once flushed.
    always @(posedge clk) begin
        if (rst_i) since_rst <= 0;
        else if (since_rst < 1000) since_rst <= since_rst + 1;
    end

    always @(negedge clk) begin
        if (since_rst >= 3) check("vout_sv2", W'(u_dut.core_v), W'(u_dut.sv_q[2]));
    end

    logic [W-1:0] va[3], vb[3], vs[3];
    logic         vc[3];
    int           drops, first_iss, first_valid, n_acc, stale;

    initial begin
        va = '{32'h7FFF_FFFF, 32'h00FF_00FF, 32'hFFFF_FFFF};
        vb = '{32'h0000_0000, 32'h0001_0001, 32'hFFFF_FFFF};
        vc = '{1'b1, 1'b1, 1'b1};
        vs = '{32'h8000_0000, 32'h0100_0101, 32'hFFFF_FFFF};

        repeat (2) @(negedge clk);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h5, 32'h6, 1'b0, 1'b1);
        check("rst_ready", W'(obs_ready), W'(1'b0));
        idle(1'b1);
        check("rel_ready", W'(obs_ready), W'(1'b1));

        // single op with wrap to zero
        step(1'b0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b1);
        repeat (3) idle(1'b1);
        check("single_early", W'(obs_valid), W'(1'b0));
        idle(1'b1);
        check("single_valid", W'(obs_valid), W'(1'b1));
        check("single_sum", obs_sum, 32'h0000_0000);
        idle(1'b1);
        check("single_after", W'(obs_valid), W'(1'b0));

        // carry chains, back to back
        popped.delete();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, va[i], vb[i], vc[i], 1'b1);
        repeat (6) idle(1'b1);
        check("chain_count", W'(popped.size()), W'(3));
        for (int i = 0; i < 3; i++) begin
            if (i < popped.size()) check("chain_sum", popped[i], vs[i]);
        end

        // full-rate stream
        n_pop = 0;
        drops = 0;
        first_iss = cyc;
        first_valid = -1;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b1, $urandom, $urandom, 1'($urandom_range(1)), 1'b1);
            if (!obs_ready) drops++;
            if (obs_valid && first_valid < 0) first_valid = cyc - 1;
        end
        repeat (8) idle(1'b1);
        check("full_drops", W'(drops), W'(0));
        check("full_pops", W'(n_pop), W'(100));
        check("full_first_lat", W'(first_valid - first_iss), W'(4));

        // backpressure
        n_acc = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
            if (obs_ready) n_acc++;
        end
        check("bp_accept", W'(n_acc), W'(8));
        check("bp_stall", W'(obs_ready), W'(1'b0));
        step(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b1);
        check("bp_head", W'(obs_valid), W'(1'b1));
        check("bp_full", W'(obs_ready), W'(1'b0));
        step(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
        check("bp_credit", W'(obs_ready), W'(1'b1));
        step(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
        check("bp_refull", W'(obs_ready), W'(1'b0));
        repeat (14) idle(1'b1);
        check("bp_drained", W'(obs_valid), W'(1'b0));

        // random traffic, pointer wrap
        n_iss = 0;
        n_pop = 0;
        repeat (2000) step(1'b0, 1'($urandom_range(1)), $urandom, $urandom,
                           1'($urandom_range(1)), 1'($urandom_range(1)));
        repeat (20) idle(1'b1);
        check("rand_count", W'(n_pop), W'(n_iss));
        check("rand_empty", W'(obs_valid), W'(1'b0));

        // reset with operations in flight
        step(1'b0, 1'b1, 32'hAAAA_0000, 32'h0000_5555, 1'b0, 1'b1);
        step(1'b0, 1'b1, 32'h1000_0000, 32'h2000_0000, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'h0BAD_0000, 32'h0000_0BAD, 1'b0, 1'b1);
        check("mid_rst_ready", W'(obs_ready), W'(1'b0));
        step(1'b0, 1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1);
        check("mid_rel_ready", W'(obs_ready), W'(1'b1));
        stale = 0;
        repeat (3) begin
            idle(1'b1);
            if (obs_valid) stale++;
        end
        check("mid_stale", W'(stale), W'(0));
        idle(1'b1);
        check("mid_valid", W'(obs_valid), W'(1'b1));
        check("mid_sum", obs_sum, 32'h2345_678A);
        idle(1'b1);
        check("mid_after", W'(obs_valid), W'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
